seq_alu: RTL

- Parametrised, multi-cycle successor to the single-cycle 64-bit datapath ALU.
- Add, sub and pass-A complete in one cycle. Multiply (shift-add) and unsigned divide (restoring) are iterative, so no combinational multiplier or divider is needed.
- Adds a valid/ready handshake, NZCV flags and a divide-by-zero flag.
- Sits in the EX stage; the hazard unit stalls the pipeline while in_ready=0.

---
 rtl/seq_alu_pkg.sv | 19 +
 rtl/seq_alu_iter_muldiv.sv | 84 ++++++++
 rtl/seq_alu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU and the control unit.
//   - ALU operation codes (3-bit alu_operation encoding)
//   - FSM state encoding used by seq_alu
package seq_alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MUL  = 3'b100;
  localparam logic [2:0] ALU_DIV  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } alu_state_t;

endpackage

// File: rtl/seq_alu_iter_muldiv.sv
// iter_muldiv: iterative shift-add multiplier / restoring unsigned divider.
// One bit per i_step cycle, WIDTH steps per operation.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (control only)
//   i_start     - latch operands and clear the iteration counter
//   i_div       - mode at start: 1 = divide, 0 = multiply
//   i_a, i_b    - multiplicand/multiplier or dividend/divisor
//   i_step      - perform one iteration this cycle
//   o_last      - the current step is the final (WIDTH-th) iteration
//   o_res_next  - result value after the current step (product or quotient)
module iter_muldiv #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_step,
  output logic             o_last,
  output logic [WIDTH-1:0] o_res_next
);

  // r_acc : product accumulator (mul) / partial remainder (div)
  // r_opa : shifted multiplicand (mul) / dividend shifting into quotient (div)
  // r_opb : multiplier shifted right (mul) / divisor (div)
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div;

  logic [WIDTH-1:0] w_acc_mul;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  always_comb begin
    w_acc_mul  = r_acc + (r_opb[0] ? r_opa : '0);
    // Restoring step: bring in next dividend bit, try to subtract the divisor.
    w_rem_sh   = {r_acc, r_opa[WIDTH-1]};
    w_borrow   = (w_rem_sh < {1'b0, r_opb});
    // When no borrow the difference is below the divisor, so WIDTH bits suffice.
    w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_opb;
    w_rem_next = w_borrow ? w_rem_sh[WIDTH-1:0] : w_rem_sub;
    w_quo_next = {r_opa[WIDTH-2:0], ~w_borrow};
    o_res_next = r_div ? w_quo_next : w_acc_mul;
    o_last     = (r_cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (i_start) begin
      r_cnt <= '0;
      r_div <= i_div;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_acc <= '0;
      r_opa <= i_a;
      r_opb <= i_b;
    end else if (i_step) begin
      if (r_div) begin
        r_acc <= w_rem_next;
        r_opa <= w_quo_next;
      end else begin
        r_acc <= w_acc_mul;
        r_opa <= r_opa << 1;
        r_opb <= r_opb >> 1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle EX-stage ALU with valid/ready handshake.
// add/sub/pass/other complete in one cycle; mul and unsigned div iterate
// WIDTH cycles in iter_muldiv. Result and flags are registered.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid / in_ready - input handshake (in_ready high only in IDLE)
//   alu_operation       - 3-bit op code (see seq_alu_pkg)
//   a_in, b_in          - operands, latched at accept
//   out_valid/out_ready - output handshake
//   result              - registered result
//   zero, negative, carry, overflow, div_by_zero - registered flags
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_operation,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  alu_state_t       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_negative, r_carry, r_overflow, r_dbz;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_c, w_sc_v, w_sc_dbz;
  logic [WIDTH-1:0] w_fin_res;
  logic             w_fin_c, w_fin_v, w_fin_dbz;
  logic             w_accept, w_start, w_step, w_load;
  logic             w_is_mul, w_is_div, w_b_zero;
  logic             w_md_last;
  logic [WIDTH-1:0] w_md_res;

  iter_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_div      (w_is_div),
    .i_a        (a_in),
    .i_b        (b_in),
    .i_step     (w_step),
    .o_last     (w_md_last),
    .o_res_next (w_md_res)
  );

  always_comb begin
    w_sum    = {1'b0, a_in} + {1'b0, b_in};
    w_dif    = {1'b0, a_in} - {1'b0, b_in};
    w_is_mul = (alu_operation == ALU_MUL);
    w_is_div = (alu_operation == ALU_DIV);
    w_b_zero = (b_in == '0);
    w_sc_res = '0;
    w_sc_c   = 1'b0;
    w_sc_v   = 1'b0;
    w_sc_dbz = 1'b0;
    case (alu_operation)
      ALU_ADD: begin
        w_sc_res = w_sum[WIDTH-1:0];
        w_sc_c   = w_sum[WIDTH];
        w_sc_v   = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (w_sum[WIDTH-1] != a_in[WIDTH-1]);
      end
      ALU_SUB: begin
        w_sc_res = w_dif[WIDTH-1:0];
        // ARM convention: carry set means no borrow (a >= b unsigned).
        w_sc_c   = ~w_dif[WIDTH];
        w_sc_v   = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (w_dif[WIDTH-1] != a_in[WIDTH-1]);
      end
      ALU_PASS: w_sc_res = a_in;
      ALU_DIV: begin
        // Only reached as a single-cycle op when the divisor is zero.
        w_sc_res = '1;
        w_sc_dbz = 1'b1;
      end
      default: ;
    endcase

    w_accept = in_valid && r_in_ready;
    w_start  = w_accept && (w_is_mul || (w_is_div && !w_b_zero));
    w_step   = (r_state == ST_MUL) || (r_state == ST_DIV);
    w_load   = (w_accept && !w_start) || (w_step && w_md_last);

    w_fin_res = w_step ? w_md_res : w_sc_res;
    w_fin_c   = w_step ? 1'b0 : w_sc_c;
    w_fin_v   = w_step ? 1'b0 : w_sc_v;
    w_fin_dbz = w_step ? 1'b0 : w_sc_dbz;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (w_start) begin
              r_state <= w_is_div ? ST_DIV : ST_MUL;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_md_last) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_load) begin
        r_result   <= w_fin_res;
        r_zero     <= (w_fin_res == '0);
        r_negative <= w_fin_res[WIDTH-1];
        r_carry    <= w_fin_c;
        r_overflow <= w_fin_v;
        r_dbz      <= w_fin_dbz;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign zero        = r_zero;
  assign negative    = r_negative;
  assign carry       = r_carry;
  assign overflow    = r_overflow;
  assign div_by_zero = r_dbz;

endmodule
